// File: rtl/loop_data_in_ctrl_pkg.sv
// loop_ctrl_pkg
// Shared definitions for the channel loop memory sequencer:
//   - controller state encoding (FILL=0, REPLAY=1) and its width
//   - wrap_inc(): increment a counter value, wrapping to zero past a maximum
package loop_ctrl_pkg;

  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Next value of a counter that runs 0..maxVal and then wraps back to 0.
  function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned maxVal);
    return (cur >= maxVal) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/loop_data_in_ctrl_if.sv
// loop_data_in_ctrl_if
// Bundles the upstream/downstream handshake and the loop memory controls of
// the channel loop sequencer.
//   valid_in   : upstream presents a channel value
//   ready_in   : sequencer accepts a channel value
//   out_ready  : downstream can take a replayed value
//   write      : memory write enable,  wr_ptr : memory write address
//   read       : memory read enable,   rd_ptr : memory read address
//   last_out   : final replayed value of the pixel (aligned with memory data)
//   pixel_done : one-cycle pulse, pixel fully replayed
//   busy       : sequencer is replaying
// Modport master is the environment side, slave is the sequencer side.
interface loop_data_in_ctrl_if #(
  parameter int POINTER_WIDTH_LOOP = 7
) ();

  logic                          valid_in;
  logic                          ready_in;
  logic                          out_ready;
  logic                          write;
  logic [POINTER_WIDTH_LOOP-1:0] wr_ptr;
  logic                          read;
  logic [POINTER_WIDTH_LOOP-1:0] rd_ptr;
  logic                          last_out;
  logic                          pixel_done;
  logic                          busy;

  modport master (
    output valid_in, out_ready,
    input  ready_in, write, wr_ptr, read, rd_ptr, last_out, pixel_done, busy
  );

  modport slave (
    input  valid_in, out_ready,
    output ready_in, write, wr_ptr, read, rd_ptr, last_out, pixel_done, busy
  );

endinterface

// File: rtl/loop_data_in_ctrl_mod_counter.sv
// mod_counter
// Wrap counter running 0..MAX. Advances on en_i, returns to zero on clr_i
// (clear has priority), and flags the terminal value on tc_o.
//   clk, reset : clock and asynchronous active-low reset
//   en_i       : advance one step
//   clr_i      : synchronous clear to zero
//   count_o    : current count
//   tc_o       : count is at MAX
module mod_counter
  import loop_ctrl_pkg::*;
#(
  parameter int          WIDTH = 7,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over advance, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = WIDTH'(wrap_inc(32'(count_q), MAX));
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == WIDTH'(MAX));

endmodule

// File: rtl/loop_data_in_ctrl.sv
// loop_data_in_ctrl
// Sequencer for the per-pixel channel loop memory. In FILL it accepts
// CHANNEL_NUM_IN_PIXEL channel values and generates write/wr_ptr. In REPLAY
// it generates read/rd_ptr to play the stored channels LOOP_NUM times,
// stalling whenever downstream is not ready. After the last read it pulses
// last_out/pixel_done and returns to FILL.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : handshake and memory controls (slave side)
module loop_data_in_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int CHANNEL_NUM_IN_PIXEL = 2,
  parameter int POINTER_WIDTH_LOOP   = 7,
  parameter int LOOP_NUM             = 4,
  parameter int LOOP_CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  loop_data_in_ctrl_if.slave   bus
);

  state_e state_q;
  logic   lastOut_q;
  logic   pixelDone_q;

  logic acceptEn;
  logic writeEn;
  logic readEn;
  logic wrTc;
  logic rdTc;
  logic loopTc;
  logic finalRead;

  logic [POINTER_WIDTH_LOOP-1:0] wrPtr;
  logic [POINTER_WIDTH_LOOP-1:0] rdPtr;
  logic [LOOP_CNT_WIDTH-1:0]     loopCnt;

  // ready_in is gated by reset directly so it drops the moment reset asserts.
  assign acceptEn  = (state_q == FILL) && reset;
  assign writeEn   = bus.valid_in && acceptEn;
  assign readEn    = (state_q == REPLAY) && bus.out_ready;
  assign finalRead = readEn && rdTc && loopTc;

  // Write address: steps on each accepted channel, wraps after the last one.
  mod_counter #(
    .WIDTH (POINTER_WIDTH_LOOP),
    .MAX   (CHANNEL_NUM_IN_PIXEL - 1)
  ) u_wrPtr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (writeEn),
    .clr_i   (1'b0),
    .count_o (wrPtr),
    .tc_o    (wrTc)
  );

  // Read address: steps on each replayed channel, wraps at end of a pass.
  mod_counter #(
    .WIDTH (POINTER_WIDTH_LOOP),
    .MAX   (CHANNEL_NUM_IN_PIXEL - 1)
  ) u_rdPtr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (readEn),
    .clr_i   (1'b0),
    .count_o (rdPtr),
    .tc_o    (rdTc)
  );

  // Pass counter: advances when a pass completes; its wrap coincides with
  // the final read, which brings it back to zero for the next pixel.
  mod_counter #(
    .WIDTH (LOOP_CNT_WIDTH),
    .MAX   (LOOP_NUM - 1)
  ) u_loopCnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (readEn && rdTc),
    .clr_i   (1'b0),
    .count_o (loopCnt),
    .tc_o    (loopTc)
  );

  // FSM plus the end-of-pixel flags, registered one cycle after the final
  // read so they line up with the memory's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      lastOut_q   <= 1'b0;
      pixelDone_q <= 1'b0;
    end else begin
      lastOut_q   <= finalRead;
      pixelDone_q <= finalRead;
      case (state_q)
        FILL:    if (writeEn && wrTc) state_q <= REPLAY;
        REPLAY:  if (finalRead)       state_q <= FILL;
      endcase
    end
  end

  // The pass counter never runs past the configured number of replays.
  loopCntInRange: assert property (@(posedge clk) disable iff (!reset)
    32'(loopCnt) < 32'(LOOP_NUM));

  assign bus.ready_in   = acceptEn;
  assign bus.write      = writeEn;
  assign bus.wr_ptr     = wrPtr;
  assign bus.read       = readEn;
  assign bus.rd_ptr     = rdPtr;
  assign bus.last_out   = lastOut_q;
  assign bus.pixel_done = pixelDone_q;
  assign bus.busy       = (state_q == REPLAY);

endmodule

// File: doc/loop_data_in_ctrl.md
# loop_data_in_ctrl

Sequencer for the per-pixel channel loop memory in the conv datapath. It accepts one pixel's worth of channel values from upstream and generates the memory's `write`/`wr_ptr` controls to capture them. It then generates `read`/`rd_ptr` to replay the stored channels `LOOP_NUM` times, once per filter pass, under downstream back-pressure. It signals end-of-pixel so the next pixel can be filled.

## Interface
- `CHANNEL_NUM_IN_PIXEL`, 2: channels per pixel; memory depth; ≥1.
- `POINTER_WIDTH_LOOP`, 7: width of `wr_ptr`/`rd_ptr`; 2^POINTER_WIDTH_LOOP ≥ CHANNEL_NUM_IN_PIXEL.
- `LOOP_NUM`, 4: replays per pixel; ≥1.
- `LOOP_CNT_WIDTH`, 8: width of internal replay counter; 2^LOOP_CNT_WIDTH ≥ LOOP_NUM.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `valid_in`  in  1  upstream presents one channel value to the memory's data input this cycle.
- `ready_in`  out  1  controller accepts a channel value this cycle.
- `out_ready`  in  1  downstream can take one replayed value.
- `write`  out  1  memory write enable.
- `wr_ptr`  out  POINTER_WIDTH_LOOP  memory write address.
- `read`  out  1  memory read enable.
- `rd_ptr`  out  POINTER_WIDTH_LOOP  memory read address.
- `last_out`  out  1  marks the final replayed value of the pixel; aligned with the memory's `valid_out`.
- `pixel_done`  out  1  one-cycle pulse: pixel fully replayed.
- `busy`  out  1  high in REPLAY.

## Operation
- Two states: FILL, REPLAY. Reset state: FILL; `wr_ptr`=`rd_ptr`=0; replay count=0.
- `ready_in` = (state==FILL) & reset deasserted. `write` = `valid_in` & `ready_in`. Both are combinational.
- FILL: each `write` increments `wr_ptr`. On a `write` with `wr_ptr`==CHANNEL_NUM_IN_PIXEL-1, `wr_ptr`→0 and state→REPLAY.
- `read` = (state==REPLAY) & `out_ready`. It is combinational. `rd_ptr` is registered.
- REPLAY: each `read` increments `rd_ptr`. At CHANNEL_NUM_IN_PIXEL-1, `rd_ptr`→0 and the replay count increments.
- Final read: `rd_ptr`==CHANNEL_NUM_IN_PIXEL-1, count==LOOP_NUM-1, and `read`=1. On this read:
  - state→FILL
  - count→0
  - `pixel_done` and `last_out` assert on the next cycle.
- `out_ready` low in REPLAY: `read`=0. Pointers and count hold.
- `valid_in` in REPLAY is ignored (`ready_in`=0). Upstream holds its value.
- CHANNEL_NUM_IN_PIXEL=1: pointers stay 0, and every fill write transitions to REPLAY. LOOP_NUM=1: a single pass.
- `busy` = (state==REPLAY).

## Timing
- Reset values, all outputs: `ready_in`=0 while reset is low; `write`, `read`, `last_out`, `pixel_done`, `busy` = 0; `wr_ptr`, `rd_ptr` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Any partially filled or replayed pixel is discarded, and upstream must resend it from channel 0.
- Fill of N channels takes N accepted cycles.
- `ready_in` drops in the cycle after the last write and returns in the cycle after the final read.
- Minimum pixel period with no stalls: CHANNEL_NUM_IN_PIXEL × (1 + LOOP_NUM) cycles.
- Memory data appears one cycle after `read`. `last_out` and `pixel_done` are registered, one cycle after the final `read`.
- Fill and replay never overlap, so there is no read/write collision at the same address.

## Structure
- Shared package `loop_ctrl_pkg` holds:
  - state encoding (FILL=0, REPLAY=1)
  - state width constant
  - a pointer-increment-with-wrap function.
- Sub-module `mod_counter` is the natural split: a parameterised wrap counter with enable, clear and a terminal-count output. It is instantiated three times: `wr_ptr`, `rd_ptr`, replay count.
- The top holds the FSM and output registers. Expected size is 150–250 lines including the counter.

## Test plan
- CHANNEL_NUM_IN_PIXEL=3, LOOP_NUM=2, reset released, `valid_in`=1 for 3 cycles → `write`=1 with `wr_ptr` 0,1,2; `ready_in`=0 from cycle 4; `busy`=1.
- Same configuration, `out_ready`=1 continuously → 6 consecutive reads with `rd_ptr` 0,1,2,0,1,2. Then `last_out` and `pixel_done` pulse once, 1 cycle after the 6th read, and `ready_in`=1 in that same cycle.
- `out_ready` pattern 1,0,1,0,… during REPLAY → `read` only on high cycles; `rd_ptr` holds across low cycles; 6 reads total, completing 12 cycles after REPLAY entry.
- `valid_in` pattern 1,0,0,1,1 in FILL → writes at `wr_ptr` 0,1,2 on the high cycles only; REPLAY entered after the 5th cycle.
- Reset driven low after 4 reads → all outputs 0 immediately. After release: `ready_in`=1, `wr_ptr`=0, `rd_ptr`=0, and no `pixel_done` is ever emitted for the aborted pixel.
- CHANNEL_NUM_IN_PIXEL=1, LOOP_NUM=1 → one write, then one read at `rd_ptr`=0, `pixel_done` the next cycle; back-to-back pixels every 2 cycles.
